// File: rtl/scan_chk_pkg.sv
// Shared types and helpers for the s27 scan unload response checker.
// Contents: FSM state enum, default chain/counter sizes, saturating increment.
package scan_chk_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      REPORT = 2'd2
   } state_e;

   localparam int unsigned DEF_CHAIN_LEN = 3;
   localparam int unsigned DEF_CNT_W     = 16;

   // Increment v unless it already holds the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/scan_unload_checker_if.sv
// Scan unload stream between the pattern sequencer and the response checker.
// master: sequencer (drives scan enable, DUT scan-out, expected bit/mask stream)
// slave : checker (observes the stream, returns exp_ready)
interface scan_unload_checker_if;
   logic test_se;
   logic test_so;
   logic exp_valid;
   logic exp_bit;
   logic exp_mask;
   logic exp_ready;

   modport master (output test_se, test_so, exp_valid, exp_bit, exp_mask,
                   input  exp_ready);
   modport slave  (input  test_se, test_so, exp_valid, exp_bit, exp_mask,
                   output exp_ready);
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear has priority over inc).
// Ports: clk, rst_n (async active-low), inc, clear, q (count, W bits).
module sat_counter
   import scan_chk_pkg::*;
#(
   parameter int unsigned W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clear,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     q <= '0;
      else if (clear) q <= '0;
      else if (inc)   q <= W'(sat_inc(32'(q), W));
   end

endmodule

// File: rtl/scan_unload_checker.sv
// On-chip response checker for the s27 scan unload: compares each shifted-out
// bit against an X-maskable expected stream and keeps per-pattern and sticky
// diagnostics.
// Ports: CK, RESETN (async active-low), start (arm one pattern), clear (sync
//   clear of counters/sticky state), scan (slave side of the unload stream),
//   busy, pattern_done/pattern_fail (one-cycle report), underrun (sticky),
//   pattern_count/fail_count (saturating), first_fail_pattern/first_fail_bit/
//   first_fail_valid (first miscompare location).
module scan_unload_checker
   import scan_chk_pkg::*;
#(
   parameter int unsigned CHAIN_LEN = DEF_CHAIN_LEN,
   parameter int unsigned CNT_W     = DEF_CNT_W,
   parameter int unsigned IDX_W     = $clog2(CHAIN_LEN) + 1
) (
   input  logic                 CK,
   input  logic                 RESETN,
   input  logic                 start,
   input  logic                 clear,
   scan_unload_checker_if.slave scan,
   output logic                 busy,
   output logic                 pattern_done,
   output logic                 pattern_fail,
   output logic                 underrun,
   output logic [CNT_W-1:0]     pattern_count,
   output logic [CNT_W-1:0]     fail_count,
   output logic [CNT_W-1:0]     first_fail_pattern,
   output logic [IDX_W-1:0]     first_fail_bit,
   output logic                 first_fail_valid
);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   bit_idx_q;
   logic               fail_flag_q;
   logic               shift_c;
   logic               miscmp_c;
   logic               arm_c;
   logic               exp_ready_c;

   // State register
   always_ff @(posedge CK or negedge RESETN) begin
      if (!RESETN) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next state and per-cycle compare decode
   always_comb begin
      state_d     = state_q;
      exp_ready_c = 1'b0;
      shift_c     = 1'b0;
      miscmp_c    = 1'b0;
      arm_c       = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SHIFT;
               arm_c   = 1'b1;
            end
         end
         SHIFT: begin
            exp_ready_c = scan.test_se;
            if (scan.test_se) begin
               shift_c  = 1'b1;
               // A shift with no expected bit still moved the chain: count it as bad.
               miscmp_c = !scan.exp_valid ||
                          (!scan.exp_mask && (scan.test_so != scan.exp_bit));
               if (bit_idx_q == IDX_W'(CHAIN_LEN - 1)) state_d = REPORT;
            end
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign scan.exp_ready = exp_ready_c;

   // Per-pattern tracking, report outputs and sticky diagnostics
   always_ff @(posedge CK or negedge RESETN) begin
      if (!RESETN) begin
         busy               <= 1'b0;
         pattern_done       <= 1'b0;
         pattern_fail       <= 1'b0;
         underrun           <= 1'b0;
         bit_idx_q          <= '0;
         fail_flag_q        <= 1'b0;
         first_fail_pattern <= '0;
         first_fail_bit     <= '0;
         first_fail_valid   <= 1'b0;
      end else begin
         busy         <= (state_d != IDLE);
         pattern_done <= (state_d == REPORT);
         pattern_fail <= (state_d == REPORT) && !clear && (fail_flag_q || miscmp_c);

         if (arm_c)        bit_idx_q <= '0;
         else if (shift_c) bit_idx_q <= bit_idx_q + IDX_W'(1);

         if (clear || arm_c)         fail_flag_q <= 1'b0;
         else if (shift_c && miscmp_c) fail_flag_q <= 1'b1;

         if (clear) begin
            underrun           <= 1'b0;
            first_fail_pattern <= '0;
            first_fail_bit     <= '0;
            first_fail_valid   <= 1'b0;
         end else begin
            if (shift_c && !scan.exp_valid) underrun <= 1'b1;
            // Capture only the earliest miscompare since the fields were last empty.
            if (shift_c && miscmp_c && !first_fail_valid && !fail_flag_q) begin
               first_fail_pattern <= pattern_count;
               first_fail_bit     <= bit_idx_q;
            end
            if (state_q == REPORT && fail_flag_q) first_fail_valid <= 1'b1;
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_pattern_cnt (
      .clk   (CK),
      .rst_n (RESETN),
      .inc   (state_q == REPORT),
      .clear (clear),
      .q     (pattern_count)
   );

   sat_counter #(.W(CNT_W)) u_fail_cnt (
      .clk   (CK),
      .rst_n (RESETN),
      .inc   ((state_q == REPORT) && fail_flag_q),
      .clear (clear),
      .q     (fail_count)
   );

endmodule

// File: tb/tb_scan_unload_checker.sv
// Self-checking bench: two checkers (16-bit and 2-bit counters) share one
// stimulus stream; a pattern-level model predicts report and sticky outputs.
module tb_scan_unload_checker;

   localparam int unsigned CL = 3;
   localparam int unsigned CW = 16;
   localparam int unsigned SW = 2;
   localparam int unsigned IW = $clog2(CL) + 1;

   logic CK = 1'b0;
   logic RESETN = 1'b0;
   logic start = 1'b0;
   logic clear = 1'b0;

   scan_unload_checker_if u_if_a ();
   scan_unload_checker_if u_if_b ();

   assign u_if_b.test_se   = u_if_a.test_se;
   assign u_if_b.test_so   = u_if_a.test_so;
   assign u_if_b.exp_valid = u_if_a.exp_valid;
   assign u_if_b.exp_bit   = u_if_a.exp_bit;
   assign u_if_b.exp_mask  = u_if_a.exp_mask;

   logic          busy_a, done_a, fail_a, ur_a, ffv_a;
   logic [CW-1:0] pc_a, fc_a, ffp_a;
   logic [IW-1:0] ffb_a;
   logic          busy_b, done_b, fail_b, ur_b, ffv_b;
   logic [SW-1:0] pc_b, fc_b, ffp_b;
   logic [IW-1:0] ffb_b;

   scan_unload_checker #(.CHAIN_LEN(CL), .CNT_W(CW)) u_dut_a (
      .CK (CK), .RESETN (RESETN), .start (start), .clear (clear), .scan (u_if_a.slave),
      .busy (busy_a), .pattern_done (done_a), .pattern_fail (fail_a), .underrun (ur_a),
      .pattern_count (pc_a), .fail_count (fc_a), .first_fail_pattern (ffp_a),
      .first_fail_bit (ffb_a), .first_fail_valid (ffv_a)
   );

   scan_unload_checker #(.CHAIN_LEN(CL), .CNT_W(SW)) u_dut_b (
      .CK (CK), .RESETN (RESETN), .start (start), .clear (clear), .scan (u_if_b.slave),
      .busy (busy_b), .pattern_done (done_b), .pattern_fail (fail_b), .underrun (ur_b),
      .pattern_count (pc_b), .fail_count (fc_b), .first_fail_pattern (ffp_b),
      .first_fail_bit (ffb_b), .first_fail_valid (ffv_b)
   );

   always #5 CK = ~CK;

   int n_checks = 0;
   int n_fails  = 0;

   // reference model state
   int m_pc_a, m_fc_a, m_ffp_a, m_pc_b, m_fc_b, m_ffp_b, m_ffb;
   bit m_ffv, m_ur;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int unsigned w);
      return (v < (1 << w) - 1) ? v + 1 : v;
   endfunction

   task automatic model_clear();
      m_pc_a = 0; m_fc_a = 0; m_ffp_a = 0;
      m_pc_b = 0; m_fc_b = 0; m_ffp_b = 0;
      m_ffb = 0; m_ffv = 1'b0; m_ur = 1'b0;
   endtask

   task automatic check_status(input string tag);
      chk({tag, ".pc_a"},  32'(pc_a),  32'(m_pc_a));
      chk({tag, ".fc_a"},  32'(fc_a),  32'(m_fc_a));
      chk({tag, ".ffp_a"}, 32'(ffp_a), 32'(m_ffp_a));
      chk({tag, ".pc_b"},  32'(pc_b),  32'(m_pc_b));
      chk({tag, ".fc_b"},  32'(fc_b),  32'(m_fc_b));
      chk({tag, ".ffp_b"}, 32'(ffp_b), 32'(m_ffp_b));
      chk({tag, ".ffb"},   32'({ffb_b, ffb_a}), 32'({IW'(m_ffb), IW'(m_ffb)}));
      chk({tag, ".ffv"},   32'({ffv_b, ffv_a}), 32'({m_ffv, m_ffv}));
      chk({tag, ".ur"},    32'({ur_b, ur_a}),   32'({m_ur, m_ur}));
      chk({tag, ".busy"},  32'({busy_b, busy_a}), 32'(0));
      chk({tag, ".done"},  32'({done_b, done_a}), 32'(0));
   endtask

   // Runs one pattern; bit i of each vector is the i-th unloaded bit.
   task automatic run_pattern(input string tag, input logic [CL-1:0] so, input logic [CL-1:0] eb,
                              input logic [CL-1:0] em, input logic [CL-1:0] ev,
                              input int stall_at, input int stall_len,
                              input bit clr_rep, input bit start_rep);
      bit fail;
      int fb;
      fail = 1'b0;
      fb   = -1;
      for (int i = 0; i < int'(CL); i++) begin
         if (!ev[i] || (!em[i] && so[i] != eb[i])) begin
            fail = 1'b1;
            if (fb < 0) fb = i;
         end
         if (!ev[i]) m_ur = 1'b1;
      end
      if (fail && !m_ffv) begin
         m_ffp_a = m_pc_a;
         m_ffp_b = m_pc_b;
         m_ffb   = fb;
      end

      u_if_a.test_se = 1'b0;
      start = 1'b1;
      @(posedge CK); #1;
      start = 1'b0;
      for (int i = 0; i < int'(CL); i++) begin
         if (i == stall_at) begin
            for (int s = 0; s < stall_len; s++) begin
               u_if_a.test_se   = 1'b0;
               u_if_a.test_so   = 1'($urandom);
               u_if_a.exp_valid = 1'($urandom);
               u_if_a.exp_bit   = 1'($urandom);
               #1;
               chk({tag, ".stall_rdy"}, 32'({u_if_b.exp_ready, u_if_a.exp_ready}), 32'(0));
               chk({tag, ".stall_done"}, 32'({done_b, done_a}), 32'(0));
               @(posedge CK); #1;
            end
         end
         u_if_a.test_se   = 1'b1;
         u_if_a.test_so   = so[i];
         u_if_a.exp_valid = ev[i];
         u_if_a.exp_bit   = eb[i];
         u_if_a.exp_mask  = em[i];
         #1;
         chk({tag, ".rdy"}, 32'({u_if_b.exp_ready, u_if_a.exp_ready}), 32'(3));
         chk({tag, ".busy_sh"}, 32'({busy_b, busy_a, done_b, done_a}), 32'(4'b1100));
         @(posedge CK); #1;
      end
      // report cycle
      u_if_a.test_se = 1'b0;
      clear = clr_rep;
      start = start_rep;
      #1;
      chk({tag, ".done"}, 32'({done_b, done_a}), 32'(3));
      chk({tag, ".pfail"}, 32'({fail_b, fail_a}), 32'({fail, fail}));
      chk({tag, ".rdy_rep"}, 32'({u_if_b.exp_ready, u_if_a.exp_ready}), 32'(0));
      @(posedge CK); #1;
      clear = 1'b0;
      start = 1'b0;
      if (clr_rep) begin
         model_clear();
      end else begin
         m_pc_a = sat(m_pc_a, CW);
         m_pc_b = sat(m_pc_b, SW);
         if (fail) begin
            m_fc_a = sat(m_fc_a, CW);
            m_fc_b = sat(m_fc_b, SW);
            m_ffv  = 1'b1;
         end
      end
      check_status(tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      logic [CL-1:0] so, eb, em, ev;
      u_if_a.test_se = 1'b0; u_if_a.test_so = 1'b0; u_if_a.exp_valid = 1'b0;
      u_if_a.exp_bit = 1'b0; u_if_a.exp_mask = 1'b0;
      model_clear();
      #12;
      check_status("reset");
      RESETN = 1'b1;
      @(posedge CK); #1;

      // scan enable while idle is ignored
      u_if_a.test_se = 1'b1;
      u_if_a.exp_valid = 1'b1;
      #1;
      chk("idle_rdy", 32'({u_if_b.exp_ready, u_if_a.exp_ready}), 32'(0));
      @(posedge CK); #1;
      u_if_a.test_se = 1'b0;
      check_status("idle_se");

      run_pattern("pass",   3'b101, 3'b101, 3'b000, 3'b111, -1, 0, 1'b0, 1'b0);
      run_pattern("masked", 3'b101, 3'b111, 3'b010, 3'b111, -1, 0, 1'b0, 1'b0);
      run_pattern("p1_bit2", 3'b101, 3'b001, 3'b000, 3'b111, -1, 0, 1'b0, 1'b0);
      run_pattern("stall",  3'b110, 3'b110, 3'b000, 3'b111, 1, 2, 1'b0, 1'b1);
      run_pattern("underrun", 3'b011, 3'b011, 3'b000, 3'b101, -1, 0, 1'b0, 1'b0);
      run_pattern("clr_rep", 3'b000, 3'b111, 3'b000, 3'b111, -1, 0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++)
         run_pattern("satfail", 3'b000, 3'b010, 3'b000, 3'b111, -1, 0, 1'b0, 1'b0);

      // reset after two unloaded bits
      start = 1'b1;
      @(posedge CK); #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         u_if_a.test_se = 1'b1; u_if_a.exp_valid = 1'b1;
         u_if_a.test_so = 1'b1; u_if_a.exp_bit = 1'b0; u_if_a.exp_mask = 1'b0;
         @(posedge CK); #1;
      end
      RESETN = 1'b0;
      #1;
      model_clear();
      check_status("rst_mid");
      chk("rst_rdy", 32'({u_if_b.exp_ready, u_if_a.exp_ready}), 32'(0));
      @(posedge CK); #1;
      RESETN = 1'b1;
      u_if_a.test_se = 1'b0;
      run_pattern("after_rst", 3'b010, 3'b010, 3'b000, 3'b111, -1, 0, 1'b0, 1'b0);

      // randomized patterns
      for (int n = 0; n < 150; n++) begin
         so = 3'($urandom);
         eb = so ^ (($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b000);
         em = 3'($urandom) & 3'($urandom);
         ev = ($urandom_range(0, 7) == 0) ? ~3'(1 << $urandom_range(0, 2)) : 3'b111;
         run_pattern("rnd", so, eb, em, ev, int'($urandom_range(0, CL - 1)),
                     int'($urandom_range(0, 2)), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 19) == 0) begin
            clear = 1'b1;
            @(posedge CK); #1;
            clear = 1'b0;
            model_clear();
            check_status("idle_clr");
         end
         for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
            u_if_a.test_se = 1'($urandom);
            #1;
            chk("gap_rdy", 32'({u_if_b.exp_ready, u_if_a.exp_ready}), 32'(0));
            @(posedge CK); #1;
            u_if_a.test_se = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule
